// File: rtl/acs_unit_if.sv
`default_nettype none
// ============================================================================
// acs_unit_if : BMU-to-ACS input bundle and ACS survivor/metric outputs.
// Revision    : 1.0
// ============================================================================
interface acs_unit_if #(
  parameter int PM_W = 5
);
  logic [1:0]      bit_pair_input;
  logic [3:0]      branch_metric_000;
  logic [3:0]      branch_metric_001;
  logic [3:0]      branch_metric_010;
  logic [3:0]      branch_metric_011;
  logic [3:0]      branch_metric_100;
  logic [3:0]      branch_metric_101;
  logic [3:0]      branch_metric_110;
  logic [3:0]      branch_metric_111;
  logic            valid_in;
  logic [PM_W-1:0] pm_00;
  logic [PM_W-1:0] pm_01;
  logic [PM_W-1:0] pm_10;
  logic [PM_W-1:0] pm_11;
  logic [3:0]      decision;
  logic [1:0]      best_state;
  logic            valid_out;

  modport master (
    output bit_pair_input, valid_in,
    output branch_metric_000, branch_metric_001, branch_metric_010, branch_metric_011,
    output branch_metric_100, branch_metric_101, branch_metric_110, branch_metric_111,
    input  pm_00, pm_01, pm_10, pm_11, decision, best_state, valid_out
  );

  modport slave (
    input  bit_pair_input, valid_in,
    input  branch_metric_000, branch_metric_001, branch_metric_010, branch_metric_011,
    input  branch_metric_100, branch_metric_101, branch_metric_110, branch_metric_111,
    output pm_00, pm_01, pm_10, pm_11, decision, best_state, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/acs_unit.sv
`default_nettype none
// ============================================================================
// acs_unit : add-compare-select stage, rate-1/2 K=3 (7,5) Viterbi decoder.
// Revision : 1.0
// ============================================================================
module acs_unit #(
  parameter int PM_W = 5
) (
  input  wire        clk,
  input  wire        rst,
  acs_unit_if.slave  bus
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;
  localparam logic [PM_W-1:0] c_PM_MAX = {PM_W{1'b1}};

  logic [0:0]      r_state;
  logic [PM_W-1:0] r_pm [4];
  logic [3:0]      r_decision;
  logic [1:0]      r_best_state;
  logic            r_valid_out;

  logic [3:0]      w_bm_in [8];
  logic [PM_W:0]   w_cand0 [4];
  logic [PM_W:0]   w_cand1 [4];
  logic [PM_W:0]   w_sel   [4];
  logic [PM_W:0]   w_diff  [4];
  logic [PM_W-1:0] w_pm_next [4];
  logic [PM_W:0]   w_min;
  logic [3:0]      w_dec;
  logic [1:0]      w_best;

  // Hamming distance between the received pair and the encoder output of a transition
  function automatic logic [1:0] f_bm(input logic [1:0] st, input logic u, input logic [1:0] rx);
    logic [1:0] w_exp;
    logic [1:0] w_x;
    w_exp = {u ^ st[0] ^ st[1], u ^ st[1]};
    w_x   = w_exp ^ rx;
    return {1'b0, w_x[1]} + {1'b0, w_x[0]};
  endfunction

  assign w_bm_in[0] = bus.branch_metric_000;
  assign w_bm_in[1] = bus.branch_metric_001;
  assign w_bm_in[2] = bus.branch_metric_010;
  assign w_bm_in[3] = bus.branch_metric_011;
  assign w_bm_in[4] = bus.branch_metric_100;
  assign w_bm_in[5] = bus.branch_metric_101;
  assign w_bm_in[6] = bus.branch_metric_110;
  assign w_bm_in[7] = bus.branch_metric_111;

  always_comb begin
    w_min  = '1;
    w_dec  = 4'b0000;
    w_best = 2'b00;
    for (int s = 0; s < 4; s++) begin
      if (r_state == c_IDLE) begin
        w_cand0[s] = {{(PM_W-3){1'b0}}, w_bm_in[s]};
        w_cand1[s] = {{(PM_W-3){1'b0}}, w_bm_in[s+4]};
      end else begin
        // Next state {b,u} is reached from {0,b} and {1,b}
        w_cand0[s] = {1'b0, r_pm[{1'b0, s[1]}]}
                   + {{(PM_W-1){1'b0}}, f_bm({1'b0, s[1]}, s[0], bus.bit_pair_input)};
        w_cand1[s] = {1'b0, r_pm[{1'b1, s[1]}]}
                   + {{(PM_W-1){1'b0}}, f_bm({1'b1, s[1]}, s[0], bus.bit_pair_input)};
      end
      w_dec[s] = (w_cand1[s] < w_cand0[s]);
      w_sel[s] = w_dec[s] ? w_cand1[s] : w_cand0[s];
      if (w_sel[s] < w_min) w_min = w_sel[s];
    end
    for (int s = 3; s >= 0; s--) begin
      w_diff[s]    = w_sel[s] - w_min;
      w_pm_next[s] = w_diff[s][PM_W] ? c_PM_MAX : w_diff[s][PM_W-1:0];
      if (w_pm_next[s] == '0) w_best = s[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_decision   <= 4'b0000;
      r_best_state <= 2'b00;
      r_valid_out  <= 1'b0;
      for (int s = 0; s < 4; s++) r_pm[s] <= '0;
    end else begin
      r_valid_out <= bus.valid_in;
      r_state     <= bus.valid_in ? c_RUN : c_IDLE;
      if (bus.valid_in) begin
        r_decision   <= w_dec;
        r_best_state <= w_best;
        for (int s = 0; s < 4; s++) r_pm[s] <= w_pm_next[s];
      end
    end
  end

  assign bus.pm_00      = r_pm[0];
  assign bus.pm_01      = r_pm[1];
  assign bus.pm_10      = r_pm[2];
  assign bus.pm_11      = r_pm[3];
  assign bus.decision   = r_decision;
  assign bus.best_state = r_best_state;
  assign bus.valid_out  = r_valid_out;

endmodule
`default_nettype wire
